// File: rtl/fft32_pkg.sv
// fft32_pkg: shared sizes, FSM encoding and write-slot type for the 32-point FFT scheduler.
package fft32_pkg;
    localparam int FFT_N     = 32;
    localparam int FFT_LOG2N = 5;
    localparam int TW_W      = 4;
    localparam int ADDR_W    = 5;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
    } wr_slot_t;
endpackage

// File: rtl/fft32_bf_addr_gen.sv
// fft32_bf_addr_gen: maps (stage, butterfly k) to radix-2 DIT operand addresses and twiddle index.
module fft32_bf_addr_gen
    import fft32_pkg::*;
(
    input  logic [2:0]        stage,
    input  logic [TW_W-1:0]   k,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [TW_W-1:0]   tw_idx
);
    logic [ADDR_W-1:0] span, pos, grp;
    always_comb begin
        span   = ADDR_W'(1) << stage;
        pos    = {1'b0, k} & (span - ADDR_W'(1));
        grp    = {1'b0, k} >> stage;
        addr_a = (grp << (stage + 3'd1)) | pos;
        addr_b = addr_a + span;
        tw_idx = pos[TW_W-1:0] << (3'(TW_W) - stage);
    end
endmodule

// File: rtl/fft32_stage_scheduler.sv
// fft32_stage_scheduler: issues 16 butterflies per stage over 5 stages, drains the
// butterfly pipeline between stages, and replays issued addresses as write-backs.
module fft32_stage_scheduler
    import fft32_pkg::*;
#(
    parameter int PIPE_LAT = 3,
    parameter int N_STAGES = FFT_LOG2N
) (
    input  logic              clk_50,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [2:0]        stage,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [TW_W-1:0]   tw_idx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_a,
    output logic [ADDR_W-1:0] wr_addr_b
);
    logic [1:0]        state;
    logic [TW_W-1:0]   k;
    logic [2:0]        dcnt;
    logic [ADDR_W-1:0] ga, gb;
    logic [TW_W-1:0]   gtw;
    wr_slot_t          dl [PIPE_LAT];

    fft32_bf_addr_gen u_addr_gen (
        .stage  (stage),
        .k      (k),
        .addr_a (ga),
        .addr_b (gb),
        .tw_idx (gtw)
    );

    assign rd_en     = state == RUN;
    assign done      = state == DONE;
    assign busy      = state == RUN || state == DRAIN;
    assign rd_addr_a = rd_en ? ga : '0;
    assign rd_addr_b = rd_en ? gb : '0;
    assign tw_idx    = rd_en ? gtw : '0;
    assign wr_en     = dl[PIPE_LAT-1].en;
    assign wr_addr_a = dl[PIPE_LAT-1].a;
    assign wr_addr_b = dl[PIPE_LAT-1].b;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            stage <= '0;
            k     <= '0;
            dcnt  <= '0;
        end else if (state == IDLE) begin
            state <= start ? RUN : IDLE;
            k     <= '0;
        end else if (state == RUN) begin
            if (&k) begin
                state <= DRAIN;
                dcnt  <= 3'd1;
            end else begin
                k <= k + 1'b1;
            end
        end else if (state == DRAIN) begin
            // last write of this stage lands in the final DRAIN cycle
            if (dcnt == 3'(PIPE_LAT)) begin
                dcnt  <= '0;
                k     <= '0;
                state <= (stage < 3'(N_STAGES - 1)) ? RUN : DONE;
                stage <= (stage < 3'(N_STAGES - 1)) ? stage + 1'b1 : '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end else begin
            state <= IDLE;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) dl[i] <= '0;
        end else begin
            dl[0] <= wr_slot_t'{rd_en, rd_addr_a, rd_addr_b};
            for (int i = 1; i < PIPE_LAT; i++) dl[i] <= dl[i-1];
        end
    end
endmodule

// File: tb/tb_fft32_stage_scheduler.sv
// tb_fft32_stage_scheduler: randomized-start checks of the FFT stage scheduler
// against a cycle-indexed schedule model built from group/position enumeration.
module tb_fft32_stage_scheduler;
    localparam int L    = 3;
    localparam int T    = 16 + L;
    localparam int LAST = 5 * T;

    logic       clk_50 = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start  = 1'b0;
    logic       busy, done, rd_en, wr_en;
    logic [2:0] stage;
    logic [4:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [3:0] tw_idx;

    int sa [5][16];
    int sb [5][16];
    int stw[5][16];
    int errs   = 0;
    int checks = 0;
    int rd_cnt, wr_cnt;

    fft32_stage_scheduler #(.PIPE_LAT(L)) dut (
        .clk_50    (clk_50),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_idx    (tw_idx),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    always #10 clk_50 = ~clk_50;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // cycle c counts from the edge that sampled start (cycle 1 = first issue)
    function automatic void issue(input int c, output bit rd, output int s,
                                  output int a, output int b, output int tw);
        int off;
        rd = 0; s = 0; a = 0; b = 0; tw = 0;
        if (c >= 1 && c <= LAST) begin
            s   = (c - 1) / T;
            off = (c - 1) % T;
            if (off < 16) begin
                rd = 1;
                a  = sa[s][off];
                b  = sb[s][off];
                tw = stw[s][off];
            end
        end
    endfunction

    task automatic check_cycle(input int c, input string ph);
        bit rd, wr;
        int s, a, b, tw, ws, wa, wb, wtw;
        issue(c, rd, s, a, b, tw);
        issue(c - L, wr, ws, wa, wb, wtw);
        chk($sformatf("%s c%0d busy", ph, c), int'(busy), int'(c >= 1 && c <= LAST));
        chk($sformatf("%s c%0d done", ph, c), int'(done), int'(c == LAST + 1));
        chk($sformatf("%s c%0d stage", ph, c), int'(stage), s);
        chk($sformatf("%s c%0d rd_en", ph, c), int'(rd_en), int'(rd));
        chk($sformatf("%s c%0d rd_a", ph, c), int'(rd_addr_a), a);
        chk($sformatf("%s c%0d rd_b", ph, c), int'(rd_addr_b), b);
        chk($sformatf("%s c%0d tw", ph, c), int'(tw_idx), tw);
        chk($sformatf("%s c%0d wr_en", ph, c), int'(wr_en), int'(wr));
        chk($sformatf("%s c%0d wr_a", ph, c), int'(wr_addr_a), wa);
        chk($sformatf("%s c%0d wr_b", ph, c), int'(wr_addr_b), wb);
    endtask

    task automatic launch();
        @(negedge clk_50);
        start = 1'b1;
        @(posedge clk_50);
    endtask

    task automatic run_one(input string ph);
        launch();
        rd_cnt = 0;
        wr_cnt = 0;
        for (int c = 1; c <= 98; c++) begin
            @(negedge clk_50);
            check_cycle(c, ph);
            rd_cnt += int'(rd_en);
            wr_cnt += int'(wr_en);
            if (c == 4)  begin chk("s0k3 a", int'(rd_addr_a), 6); chk("s0k3 b", int'(rd_addr_b), 7);  chk("s0k3 tw", int'(tw_idx), 0); end
            if (c == 44) begin chk("s2k5 a", int'(rd_addr_a), 9); chk("s2k5 b", int'(rd_addr_b), 13); chk("s2k5 tw", int'(tw_idx), 4); end
            if (c == 82) begin chk("s4k5 a", int'(rd_addr_a), 5); chk("s4k5 b", int'(rd_addr_b), 21); chk("s4k5 tw", int'(tw_idx), 5); end
            start = (c == 10 || c == 50 || c == 96) ? 1'b1 : (c < 96 ? 1'($urandom % 2) : 1'b0);
        end
        chk({ph, " rd pulses"}, rd_cnt, 80);
        chk({ph, " wr pulses"}, wr_cnt, 80);
    endtask

    initial begin
        for (int s = 0; s < 5; s++) begin
            int span, n;
            span = 1 << s;
            n = 0;
            for (int g = 0; g < 16 / span; g++)
                for (int p = 0; p < span; p++) begin
                    sa[s][n]  = g * 2 * span + p;
                    sb[s][n]  = g * 2 * span + p + span;
                    stw[s][n] = p * (16 / span);
                    n++;
                end
        end

        #5 check_cycle(0, "reset");
        #15 rst_n = 1'b1;

        run_one("single");

        launch();
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_50);
            check_cycle(c, "pre_rst");
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1 check_cycle(0, "async_rst");
        @(posedge clk_50);
        @(negedge clk_50);
        check_cycle(0, "in_rst");
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_50);
            check_cycle(0, "post_rst");
        end
        run_one("restart");

        launch();
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk_50);
            check_cycle(((c - 1) % 97) + 1, $sformatf("held%0d", c));
        end
        start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
